// File: rtl/term_write_sequencer_if.sv
// rtl/term_write_sequencer_if.sv - PIA/video-memory bundle for the terminal write sequencer
// Signals:
//   char_in, char_strobe, rda, clr          : PIA port B side (character in, ready-for-data, clear request)
//   pos_valid, pos_col, pos_row             : recirculating memory write-head slot position
//   mem_we, mem_data                        : character memory write port
//   scroll_req, scroll_ack                  : one-row scroll handshake with the memory
//   cursor_col, cursor_row                  : current cursor position
// Modports: master drives the inputs of the sequencer, slave is the sequencer itself.

interface term_write_sequencer_if;
    logic [6:0] char_in;
    logic       char_strobe;
    logic       rda;
    logic       clr;
    logic       pos_valid;
    logic [5:0] pos_col;
    logic [4:0] pos_row;
    logic       mem_we;
    logic [5:0] mem_data;
    logic       scroll_req;
    logic       scroll_ack;
    logic [5:0] cursor_col;
    logic [4:0] cursor_row;

    modport master (
        output char_in, char_strobe, clr, pos_valid, pos_col, pos_row, scroll_ack,
        input  rda, mem_we, mem_data, cursor_col, cursor_row, scroll_req
    );

    modport slave (
        input  char_in, char_strobe, clr, pos_valid, pos_col, pos_row, scroll_ack,
        output rda, mem_we, mem_data, cursor_col, cursor_row, scroll_req
    );
endinterface

// File: rtl/term_write_sequencer.sv
// rtl/term_write_sequencer.sv - Apple-1 terminal character write sequencer
// Ports:
//   clk       : system clock, all state on the rising edge
//   rst       : asynchronous, active-high reset
//   bus.slave : char_in/char_strobe/rda/clr from the PIA, pos_valid/pos_col/pos_row
//               from the recirculating memory, mem_we/mem_data write port,
//               scroll_req/scroll_ack handshake, cursor_col/cursor_row outputs
// Build option: TERM_CLEAR_EN - when defined, clr sweeps CLEAR_CHAR through every
//               character slot before homing the cursor; when undefined, clr only
//               homes the cursor and abandons any pending write or scroll.

module term_write_sequencer #(
    parameter int         COLS       = 40,
    parameter int         ROWS       = 24,
    parameter logic [5:0] CLEAR_CHAR = 6'h20
) (
    input  logic                 clk,
    input  logic                 rst,
    term_write_sequencer_if.slave bus
);

    localparam logic [5:0] LAST_COL = 6'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
`ifdef TERM_CLEAR_EN
    localparam logic [9:0] LAST_SLOT = 10'(COLS * ROWS - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        WAIT_POS,
        ADVANCE,
        SCROLL,
        CLEAR
    } state_t;

    state_t     state_q, state_nx;
    logic [5:0] data_q, data_nx;
    logic       newline_q, newline_nx;
    logic [5:0] col_q, col_nx;
    logic [4:0] row_q, row_nx;
`ifdef TERM_CLEAR_EN
    logic [9:0] sweep_q, sweep_nx;
`endif

    logic       rda;
    logic       mem_we;
    logic [5:0] mem_data;
    logic       scroll_req;
    logic       printable;
    logic       is_cr;
    logic       pos_hit;

    // Only the 64-code uppercase/punctuation block is displayable; the memory
    // stores the low six bits of the code.
    assign printable = (bus.char_in >= 7'h20) && (bus.char_in <= 7'h5F);
    assign is_cr     = (bus.char_in == 7'h0D);
    assign pos_hit   = bus.pos_valid && (bus.pos_col == col_q) && (bus.pos_row == row_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= 6'd0;
            newline_q <= 1'b0;
            col_q     <= 6'd0;
            row_q     <= 5'd0;
`ifdef TERM_CLEAR_EN
            sweep_q   <= 10'd0;
`endif
        end else begin
            state_q   <= state_nx;
            data_q    <= data_nx;
            newline_q <= newline_nx;
            col_q     <= col_nx;
            row_q     <= row_nx;
`ifdef TERM_CLEAR_EN
            sweep_q   <= sweep_nx;
`endif
        end
    end

    always_comb begin
        state_nx   = state_q;
        data_nx    = data_q;
        newline_nx = newline_q;
        col_nx     = col_q;
        row_nx     = row_q;
`ifdef TERM_CLEAR_EN
        sweep_nx   = sweep_q;
`endif
        rda        = 1'b0;
        mem_we     = 1'b0;
        mem_data   = data_q;
        scroll_req = 1'b0;

        case (state_q)
            IDLE: begin
                rda = 1'b1;
                if (bus.char_strobe) begin
                    data_nx = bus.char_in[5:0];
                    if (printable) begin
                        state_nx = WAIT_POS;
                    end else if (is_cr) begin
                        col_nx     = 6'd0;
                        newline_nx = 1'b1;
                        state_nx   = ADVANCE;
                    end
                end
            end

            WAIT_POS: begin
                // The write head passes every slot once per revolution, so the
                // write is a single-cycle strobe on the matching slot.
                mem_we = pos_hit;
                if (pos_hit) begin
                    state_nx = ADVANCE;
                end
            end

            ADVANCE: begin
                newline_nx = 1'b0;
                if ((col_q < LAST_COL) && !newline_q) begin
                    col_nx   = col_q + 6'd1;
                    state_nx = IDLE;
                end else begin
                    col_nx = 6'd0;
                    if (row_q < LAST_ROW) begin
                        row_nx   = row_q + 5'd1;
                        state_nx = IDLE;
                    end else begin
                        // Bottom row: the memory shifts the screen up and the
                        // cursor stays on the (now blank) last row.
                        state_nx = SCROLL;
                    end
                end
            end

            SCROLL: begin
                scroll_req = 1'b1;
                if (bus.scroll_ack) begin
                    state_nx = IDLE;
                end
            end

            CLEAR: begin
                mem_data = CLEAR_CHAR;
`ifdef TERM_CLEAR_EN
                // Count writes rather than positions: the sweep starts wherever
                // the write head happens to be and covers one full revolution.
                mem_we = bus.pos_valid;
                if (bus.pos_valid) begin
                    if (sweep_q == LAST_SLOT) begin
                        sweep_nx = 10'd0;
                        col_nx   = 6'd0;
                        row_nx   = 5'd0;
                        state_nx = IDLE;
                    end else begin
                        sweep_nx = sweep_q + 10'd1;
                    end
                end
`else
                col_nx   = 6'd0;
                row_nx   = 5'd0;
                state_nx = IDLE;
`endif
            end

            default: begin
                state_nx = IDLE;
            end
        endcase

        // clr wins over everything, including a strobe in the same cycle. The
        // pending write and scroll request are cut off combinationally so no
        // stale write reaches the memory while clr is high.
        if (bus.clr) begin
            state_nx   = CLEAR;
            data_nx    = data_q;
            newline_nx = 1'b0;
            col_nx     = col_q;
            row_nx     = row_q;
            mem_we     = 1'b0;
            scroll_req = 1'b0;
`ifdef TERM_CLEAR_EN
            sweep_nx   = 10'd0;
`endif
        end
    end

    assign bus.rda        = rda;
    assign bus.mem_we     = mem_we;
    assign bus.mem_data   = mem_data;
    assign bus.scroll_req = scroll_req;
    assign bus.cursor_col = col_q;
    assign bus.cursor_row = row_q;

endmodule

// File: tb/tb_term_write_sequencer.sv
// tb/tb_term_write_sequencer.sv - self-checking bench for term_write_sequencer

module tb_term_write_sequencer;

    localparam int COLS  = 40;
    localparam int ROWS  = 24;
    localparam int SLOTS = COLS * ROWS;
    localparam int BOUND = 1200;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    term_write_sequencer_if bus();

    term_write_sequencer #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .CLEAR_CHAR (6'h20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: cursor, at most one pending character write, a clear sweep budget,
    // and whether a scroll request must be showing.
    int         mc = 0;
    int         mr = 0;
    bit         pend_valid = 1'b0;
    int         pend_col = 0;
    int         pend_row = 0;
    int         pend_armed = 0;
    logic [5:0] pend_data = 6'd0;
    int         sweep_left = 0;
    int         sweep_armed = 0;
    bit         exp_scroll = 1'b0;
    int         wr_count = 0;
    int         last_col = -1;
    int         last_row = -1;
    logic [5:0] last_data = 6'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: no completion within %0d cycles (cycle %0d)", name, BOUND, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Recirculating memory: slots 0..959 in raster order, one per pos_valid;
    // every 16th cycle carries no slot.
    int slot  = 0;
    int phase = 0;
    initial begin
        bus.pos_valid = 1'b0;
        bus.pos_col   = 6'd0;
        bus.pos_row   = 5'd0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.pos_valid) slot = (slot + 1) % SLOTS;
            phase         = (phase + 1) % 16;
            bus.pos_valid = (phase != 0);
            bus.pos_col   = 6'(slot % COLS);
            bus.pos_row   = 5'(slot / COLS);
        end
    end

    // Per-cycle compare of the memory port and scroll request.
    logic       ew;
    logic [5:0] ed;
    bit         from_sweep;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            ew         = 1'b0;
            ed         = 6'd0;
            from_sweep = 1'b0;
            if (sweep_left > 0 && cyc >= sweep_armed) begin
                ew         = bus.pos_valid;
                ed         = 6'h20;
                from_sweep = 1'b1;
            end else if (pend_valid && cyc >= pend_armed && bus.pos_valid &&
                         int'(bus.pos_col) == pend_col && int'(bus.pos_row) == pend_row) begin
                ew = 1'b1;
                ed = pend_data;
            end
            chk("mem_we", bus.mem_we, ew);
            if (ew) begin
                chk("mem_data", bus.mem_data, ed);
                if (from_sweep) begin
                    sweep_left--;
                end else begin
                    pend_valid = 1'b0;
                    wr_count++;
                    last_col  = int'(bus.pos_col);
                    last_row  = int'(bus.pos_row);
                    last_data = bus.mem_data;
                end
            end
            chk("scroll_req", bus.scroll_req, exp_scroll);
        end
    end

    // Cursor after an event: a newline goes to column 0 of the next row, a
    // placed character moves right and wraps like a newline past the last
    // column. Returns 1 when the move falls off the bottom (scroll).
    function automatic bit model_move(input bit newline);
        if (!newline) begin
            mc = mc + 1;
            if (mc < COLS) return 1'b0;
        end
        mc = 0;
        if (mr + 1 < ROWS) begin
            mr = mr + 1;
            return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic chk_cursor(input string name);
        chk({name, "_col"}, bus.cursor_col, mc);
        chk({name, "_row"}, bus.cursor_row, mr);
    endtask

    task automatic put_char(input logic [6:0] ch, input bit dup);
        bit pr;
        bit cr;
        bit scr;
        int k;
        pr = (ch >= 7'h20) && (ch <= 7'h5F);
        cr = (ch == 7'h0D);
        chk("rda_idle", bus.rda, 1'b1);
        if (pr) begin
            pend_valid = 1'b1;
            pend_col   = mc;
            pend_row   = mr;
            pend_data  = ch[5:0];
            pend_armed = cyc + 1;
        end
        bus.char_in     = ch;
        bus.char_strobe = 1'b1;
        tick();
        bus.char_strobe = 1'b0;
        if (!pr && !cr) begin
            chk("rda_ignored", bus.rda, 1'b1);
            chk_cursor("cursor_ignored");
            return;
        end
        chk("rda_busy", bus.rda, 1'b0);
        if (dup) begin
            bus.char_in     = 7'h42;
            bus.char_strobe = 1'b1;
            tick();
            bus.char_strobe = 1'b0;
        end
        if (pr) begin
            k = 0;
            while (pend_valid && k < BOUND) begin
                tick();
                k++;
            end
            if (pend_valid) begin
                timeout_fail("write_wait");
                pend_valid = 1'b0;
                return;
            end
            chk("rda_after_write", bus.rda, 1'b0);
        end
        scr = model_move(cr);
        tick();
        if (scr) begin
            exp_scroll = 1'b1;
            chk("rda_scroll", bus.rda, 1'b0);
        end else begin
            chk("rda_done", bus.rda, 1'b1);
        end
        chk_cursor("cursor_after");
    endtask

    task automatic ack_scroll(input int hold);
        for (int i = 0; i < hold; i++) begin
            chk("rda_in_scroll", bus.rda, 1'b0);
            tick();
        end
        bus.scroll_ack = 1'b1;
        tick();
        bus.scroll_ack = 1'b0;
        exp_scroll     = 1'b0;
        chk("rda_after_ack", bus.rda, 1'b1);
        chk_cursor("cursor_after_ack");
    endtask

    task automatic do_clear(input int hold, input bit with_char);
        int k;
        bus.clr    = 1'b1;
        pend_valid = 1'b0;
        exp_scroll = 1'b0;
        if (with_char) begin
            bus.char_in     = 7'h41;
            bus.char_strobe = 1'b1;
        end
        tick();
        bus.char_strobe = 1'b0;
        for (int i = 1; i < hold; i++) begin
            chk("rda_clr_held", bus.rda, 1'b0);
            tick();
        end
        bus.clr = 1'b0;
        mc = 0;
        mr = 0;
        chk("rda_clr_released", bus.rda, 1'b0);
`ifdef TERM_CLEAR_EN
        sweep_left  = SLOTS;
        sweep_armed = cyc;
        k = 0;
        while (sweep_left > 0 && k < BOUND) begin
            tick();
            k++;
        end
        if (sweep_left > 0) timeout_fail("clear_sweep");
        sweep_left = 0;
`else
        tick();
`endif
        chk("rda_after_clear", bus.rda, 1'b1);
        chk_cursor("cursor_after_clear");
    endtask

    task automatic reset_now();
        #1;
        rst             = 1'b1;
        bus.clr         = 1'b0;
        bus.char_strobe = 1'b0;
        bus.scroll_ack  = 1'b0;
        pend_valid      = 1'b0;
        sweep_left      = 0;
        exp_scroll      = 1'b0;
        mc              = 0;
        mr              = 0;
        #1;
        chk("rst_rda", bus.rda, 1'b1);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_data", bus.mem_data, 6'h00);
        chk("rst_cursor_col", bus.cursor_col, 6'd0);
        chk("rst_cursor_row", bus.cursor_row, 5'd0);
        chk("rst_scroll_req", bus.scroll_req, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: run exceeded 95000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        rst             = 1'b1;
        bus.char_in     = 7'h00;
        bus.char_strobe = 1'b0;
        bus.clr         = 1'b0;
        bus.scroll_ack  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rda", bus.rda, 1'b1);
        chk("reset_mem_we", bus.mem_we, 1'b0);
        chk("reset_mem_data", bus.mem_data, 6'h00);
        chk("reset_cursor_col", bus.cursor_col, 6'd0);
        chk("reset_cursor_row", bus.cursor_row, 5'd0);
        chk("reset_scroll_req", bus.scroll_req, 1'b0);
        rst = 1'b0;
        tick();

        // 'A' at home lands at slot (0,0) as code 0x01.
        put_char(7'h41, 1'b0);
        chk("first_write_data", last_data, 6'h01);
        chk("first_write_col", last_col, 0);
        chk("first_write_row", last_row, 0);
        chk("first_cursor_col", bus.cursor_col, 6'd1);
        chk("first_cursor_row", bus.cursor_row, 5'd0);

        // BEL is ignored; a strobe during the busy window is dropped.
        put_char(7'h07, 1'b0);
        w0 = wr_count;
        put_char(7'h43, 1'b1);
        chk("dup_strobe_writes", wr_count - w0, 1);

        // Down to row 5, then fill the row so the 40th write wraps.
        repeat (5) put_char(7'h0D, 1'b0);
        for (int i = 0; i < COLS; i++) begin
            put_char((i < 31) ? 7'(7'h41 + i) : 7'(7'h20 + i - 31), 1'b0);
            if (i < 9) put_char(7'(7'h60 + i), 1'b0);
        end
        chk("wrap_last_col", last_col, 39);
        chk("wrap_last_row", last_row, 5);
        chk("wrap_last_data", last_data, 6'h28);
        chk("wrap_cursor_col", bus.cursor_col, 6'd0);
        chk("wrap_cursor_row", bus.cursor_row, 5'd6);

        // Bottom row, column 12, then CR forces a scroll.
        repeat (17) put_char(7'h0D, 1'b0);
        for (int i = 0; i < 12; i++) put_char(7'(7'h30 + i), 1'b0);
        chk("row23_cursor_col", bus.cursor_col, 6'd12);
        chk("row23_cursor_row", bus.cursor_row, 5'd23);
        put_char(7'h0D, 1'b0);
        ack_scroll(4);
        chk("scroll_cursor_col", bus.cursor_col, 6'd0);
        chk("scroll_cursor_row", bus.cursor_row, 5'd23);

        // clr during a pending scroll drops the request at once.
        put_char(7'h0D, 1'b0);
        tick();
        do_clear(3, 1'b0);

        // clr together with a strobe: the character never gets written.
        put_char(7'h0D, 1'b0);
        do_clear(4, 1'b1);
        chk("clear_cursor_col", bus.cursor_col, 6'd0);
        chk("clear_cursor_row", bus.cursor_row, 5'd0);

        // Reset while a write is pending.
        put_char(7'h0D, 1'b0);
        pend_valid      = 1'b1;
        pend_col        = mc;
        pend_row        = mr;
        pend_data       = 6'h04;
        pend_armed      = cyc + 1;
        bus.char_in     = 7'h44;
        bus.char_strobe = 1'b1;
        tick();
        bus.char_strobe = 1'b0;
        tick();
        reset_now();

        // Reset in the middle of a clear.
        bus.clr = 1'b1;
        repeat (3) tick();
        chk("rda_mid_clear", bus.rda, 1'b0);
`ifdef TERM_CLEAR_EN
        bus.clr     = 1'b0;
        sweep_left  = SLOTS;
        sweep_armed = cyc;
        repeat (40) tick();
`endif
        reset_now();

        // A full revolution with nothing pending: any mem_we is flagged.
        repeat (BOUND) tick();
        chk("idle_rda", bus.rda, 1'b1);
        chk_cursor("idle_cursor");

        put_char(7'h41, 1'b0);
        chk("post_reset_col", bus.cursor_col, 6'd1);
        chk("post_reset_row", bus.cursor_row, 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
